hazard3_regfile_ctrl: RTL



---
 rtl/hazard3_regfile_pkg.sv | 13 +
 rtl/hazard3_regfile_init_walker.sv | 38 +++
 rtl/hazard3_regfile_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard3_regfile_pkg.sv
// Shared definitions for the Hazard3 register file controller slice.
package hazard3_regfile_pkg;

  // Controller sequencing: initialise the non-reset array, then arbitrate.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  // a0 carries the hart ID after init.
  localparam int unsigned MHARTID_IDX = 10;

endpackage

// File: rtl/hazard3_regfile_init_walker.sv
// Walks register indices 0..N_REGS-1 producing init writes, flags completion.
module hazard3_regfile_init_walker
  import hazard3_regfile_pkg::*;
#(
  parameter int unsigned       N_REGS      = 16,
  parameter int unsigned       W_DATA      = 32,
  parameter int unsigned       W_ADDR      = 5,
  parameter logic [W_DATA-1:0] MHARTID_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [W_ADDR-1:0] addr,
  output logic [W_DATA-1:0] data,
  output logic              last,
  output logic              done
);

  logic [W_ADDR-1:0] cnt;

  assign addr = cnt;
  assign last = (cnt == W_ADDR'(N_REGS - 1));
  assign data = (cnt == W_ADDR'(MHARTID_IDX)) ? MHARTID_VAL : '0;

  // Advance the walk index; latch done once the final index is written.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (last) done <= 1'b1;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard3_regfile_ctrl.sv
// Init sequencer and write/read-port-2 arbiter between core and debug module.
module hazard3_regfile_ctrl
  import hazard3_regfile_pkg::*;
#(
  parameter int unsigned       N_REGS       = 16,
  parameter int unsigned       W_DATA       = 32,
  parameter int unsigned       W_ADDR       = 5,
  parameter logic [W_DATA-1:0] MHARTID_VAL  = '0,
  parameter int unsigned       STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wen,
  input  logic [W_ADDR-1:0] core_waddr,
  input  logic [W_DATA-1:0] core_wdata,
  input  logic [W_ADDR-1:0] core_raddr1,
  input  logic [W_ADDR-1:0] core_raddr2,
  input  logic              core_rd2_en,
  output logic              core_stall,
  output logic              init_done,
  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [W_ADDR-1:0] dbg_addr,
  input  logic [W_DATA-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [W_DATA-1:0] dbg_rdata,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              rf_wen,
  input  logic [W_DATA-1:0] rf_rdata2
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  rf_state_t             state;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  force_dbg;
  logic                  wr_sel;
  logic                  dbg_wr_grant;
  logic                  dbg_rd_grant;
  logic                  core_wr;
  logic                  core_rd;
  logic [W_ADDR-1:0]     walk_addr;
  logic [W_DATA-1:0]     walk_data;
  logic                  walk_last;

  hazard3_regfile_init_walker #(
    .N_REGS      (N_REGS),
    .W_DATA      (W_DATA),
    .W_ADDR      (W_ADDR),
    .MHARTID_VAL (MHARTID_VAL)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_INIT),
    .addr  (walk_addr),
    .data  (walk_data),
    .last  (walk_last),
    .done  (init_done)
  );

  // A debug request denied STARVE_LIMIT times wins the next cycle outright.
  assign force_dbg = (state == ST_RUN) && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Port arbitration: init walk, else core first, else debug.
  always_comb begin
    // NOTE: every output gets a default up front so no path infers a latch.
    rf_raddr1    = core_raddr1;
    rf_raddr2    = core_raddr2;
    rf_waddr     = core_waddr;
    rf_wdata     = core_wdata;
    wr_sel       = 1'b0;
    dbg_wr_grant = 1'b0;
    dbg_rd_grant = 1'b0;
    core_stall   = 1'b1;
    core_wr      = 1'b0;
    core_rd      = 1'b0;
    if (state == ST_INIT) begin
      wr_sel   = 1'b1;
      rf_waddr = walk_addr;
      rf_wdata = walk_data;
    end else begin
      core_stall = force_dbg;
      core_wr    = core_wen & ~force_dbg;
      core_rd    = core_rd2_en & ~force_dbg;
      if (core_wr) begin
        wr_sel = 1'b1;
      end else if (dbg_req && dbg_write) begin
        wr_sel       = 1'b1;
        dbg_wr_grant = 1'b1;
        rf_waddr     = dbg_addr;
        rf_wdata     = dbg_wdata;
      end
      if (!core_rd && dbg_req && !dbg_write) begin
        dbg_rd_grant = 1'b1;
        rf_raddr2    = dbg_addr;
      end
    end
    // x0 is hardwired zero in RUN; the init walk still clears the BRAM word.
    rf_wen = wr_sel && ((state == ST_INIT) || (rf_waddr != '0));
  end

  assign dbg_ready = dbg_wr_grant | dbg_rd_grant;

  // The regfile registers read port 2, so its output already lines up with
  // the cycle after the grant; gate it so idle cycles read as zero.
  assign dbg_rdata = dbg_rvalid ? rf_rdata2 : '0;

  // Controller state, starvation tracking and debug read-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      starve_cnt <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      if (state == ST_INIT && walk_last) state <= ST_RUN;
      if (state == ST_INIT || !dbg_req || dbg_ready) starve_cnt <= '0;
      else                                            starve_cnt <= starve_cnt + 1'b1;
      dbg_rvalid <= dbg_rd_grant;
    end
  end

endmodule
